// File: rtl/regfile.sv
// regfile: 2R/1W general-purpose register file for the MIPS decode stage; $0 reads as zero.
// Latency: reads are combinational with a same-cycle write-through bypass; writes land on the next rising edge.
// Backpressure: none. ready stays low during the post-reset clear sweep, and the pipeline holds decode until it rises.
//
// Ports:
//   clock, reset (async, active-low)
//   write_enable / write_addr / write_data        : write-back port, applied on the rising edge
//   read_enable{1,2} / read_addr{1,2} -> read_result{1,2} : combinational read ports
//   ready                                         : high once every entry has been cleared
module regfile #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  read_enable1,
  input  logic [ADDR_WIDTH-1:0] read_addr1,
  output logic [DATA_WIDTH-1:0] read_result1,
  input  logic                  read_enable2,
  input  logic [ADDR_WIDTH-1:0] read_addr2,
  output logic [DATA_WIDTH-1:0] read_result2,
  output logic                  ready
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  // Last entry of the sweep. An explicit compare is used so that pointer
  // wrap-around can never restart the sweep.
  localparam logic [ADDR_WIDTH-1:0] PTR_LAST = {ADDR_WIDTH{1'b1}};

  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;

  // The storage array has no per-entry reset. It is cleared by the sweep instead.
  logic [DATA_WIDTH-1:0] mem_q [0:DEPTH-1];

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  // Sweep control.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == ST_CLEAR) begin
      if (ptr_q == PTR_LAST) begin
        state_d = ST_RUN;
        ptr_d   = '0;
      end else begin
        ptr_d = ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Array write port. The sweep owns the port while clearing, and any
  // write-back request in that window is dropped.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = write_addr;
    mem_wdata = write_data;
    if (state_q == ST_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = ptr_q;
      mem_wdata = '0;
    end else if (write_enable && (write_addr != '0)) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign ready = (state_q == ST_RUN);

  // Read ports. A not-ready, disabled, or $0 read yields zero. Otherwise a
  // matching in-flight write is forwarded ahead of the array contents.
  always_comb begin
    read_result1 = '0;
    if (ready && read_enable1 && (read_addr1 != '0)) begin
      if (write_enable && (write_addr == read_addr1)) begin
        read_result1 = write_data;
      end else begin
        read_result1 = mem_q[read_addr1];
      end
    end
  end

  always_comb begin
    read_result2 = '0;
    if (ready && read_enable2 && (read_addr2 != '0)) begin
      if (write_enable && (write_addr == read_addr2)) begin
        read_result2 = write_data;
      end else begin
        read_result2 = mem_q[read_addr2];
      end
    end
  end

endmodule

// File: tb/tb_regfile.sv
// tb_regfile: randomized and directed stimulus for regfile, scored against a behavioural register model.
// Latency: expectations are queued when inputs are driven, and the monitor compares them on the following falling edge.
// Backpressure: none. The bench always terminates after a fixed stimulus length.
module tb_regfile;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << AW;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          write_enable = 1'b0;
  logic [AW-1:0] write_addr = '0;
  logic [DW-1:0] write_data = '0;
  logic          read_enable1 = 1'b0;
  logic [AW-1:0] read_addr1 = '0;
  logic [DW-1:0] read_result1;
  logic          read_enable2 = 1'b0;
  logic [AW-1:0] read_addr2 = '0;
  logic [DW-1:0] read_result2;
  logic          ready;

  regfile #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock        (clock),
    .reset        (reset),
    .write_enable (write_enable),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .read_enable1 (read_enable1),
    .read_addr1   (read_addr1),
    .read_result1 (read_result1),
    .read_enable2 (read_enable2),
    .read_addr2   (read_addr2),
    .read_result2 (read_result2),
    .ready        (ready)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [DW-1:0] r1;
    logic [DW-1:0] r2;
    logic          rdy;
  } exp_t;

  exp_t exp_q[$];

  int n_compared   = 0;
  int n_mismatched = 0;
  int cyc          = 0;

  // Reference model: register contents, plus how many rising edges have
  // elapsed with reset released. The array is all zero once that count
  // reaches DEPTH.
  logic [DW-1:0] m_mem [DEPTH];
  logic          m_ready   = 1'b0;
  int            sweep_cnt = 0;
  logic          p_we      = 1'b0;
  logic [AW-1:0] p_wa      = '0;
  logic [DW-1:0] p_wd      = '0;

  function automatic logic [DW-1:0] model_read(input logic en, input logic [AW-1:0] ra);
    if (!m_ready || !en || ra == 0) return '0;
    if (p_we && p_wa == ra) return p_wd;
    return m_mem[ra];
  endfunction

  // One cycle: account for the edge just taken, then drive new inputs and
  // queue what the outputs must show before the next edge.
  task automatic step(input logic rst, input logic we, input logic [AW-1:0] wa,
                      input logic [DW-1:0] wd, input logic re1, input logic [AW-1:0] ra1,
                      input logic re2, input logic [AW-1:0] ra2);
    exp_t e;
    @(posedge clock);
    cyc++;
    if (reset) begin
      if (m_ready) begin
        if (p_we && p_wa != 0) m_mem[p_wa] = p_wd;
      end else begin
        sweep_cnt++;
        if (sweep_cnt == DEPTH) begin
          m_ready = 1'b1;
          for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        end
      end
    end
    #1;
    reset        = rst;
    write_enable = we;
    write_addr   = wa;
    write_data   = wd;
    read_enable1 = re1;
    read_addr1   = ra1;
    read_enable2 = re2;
    read_addr2   = ra2;
    if (!rst) begin
      m_ready   = 1'b0;
      sweep_cnt = 0;
    end
    p_we = we;
    p_wa = wa;
    p_wd = wd;
    e.r1  = model_read(re1, ra1);
    e.r2  = model_read(re2, ra2);
    e.rdy = m_ready;
    exp_q.push_back(e);
  endtask

  task automatic idle_read(input logic rst, input logic [AW-1:0] ra1, input logic [AW-1:0] ra2);
    step(rst, 1'b0, '0, '0, 1'b1, ra1, 1'b1, ra2);
  endtask

  // Monitor: the outputs are combinational, so sample mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_compared++;
        if (ready !== e.rdy) begin
          n_mismatched++;
          $display("FAIL ready cyc=%0d got=%0b want=%0b", cyc, ready, e.rdy);
        end
        n_compared++;
        if (read_result1 !== e.r1) begin
          n_mismatched++;
          $display("FAIL port1 cyc=%0d addr=%0d got=%h want=%h", cyc, read_addr1, read_result1, e.r1);
        end
        n_compared++;
        if (read_result2 !== e.r2) begin
          n_mismatched++;
          $display("FAIL port2 cyc=%0d addr=%0d got=%h want=%h", cyc, read_addr2, read_result2, e.r2);
        end
      end
    end
  end

  initial begin
    logic [AW-1:0] wa, ra1, ra2;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 'x;

    // Hold reset for three cycles with reads enabled. The outputs must stay zero.
    for (int i = 0; i < 3; i++) idle_read(1'b0, 5'd1, 5'd31);

    // Release reset, then write r9 on every sweep edge. These writes must be ignored.
    step(1'b1, 1'b1, 5'd9, 32'hDEADBEEF, 1'b1, 5'd9, 1'b1, 5'd9);
    for (int i = 0; i < DEPTH + 1; i++)
      step(1'b1, 1'b1, 5'd9, 32'hDEADBEEF, 1'b1, 5'd9, 1'b1, AW'(i));

    // After ready rises, every address must read back as zero.
    for (int i = 1; i < DEPTH; i++) idle_read(1'b1, AW'(i), AW'(DEPTH - i));

    // Basic write followed by read, including a disabled port.
    step(1'b1, 1'b1, 5'd5, 32'h12345678, 1'b0, 5'd0, 1'b0, 5'd0);
    idle_read(1'b1, 5'd5, 5'd5);
    step(1'b1, 1'b0, '0, '0, 1'b0, 5'd5, 1'b1, 5'd5);

    // Writes to $0 are discarded, both in the write cycle and afterwards.
    step(1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 1'b1, 5'd0);
    idle_read(1'b1, 5'd0, 5'd0);

    // Same-cycle bypass on r7, then the array holds the new value.
    step(1'b1, 1'b1, 5'd7, 32'hAAAA0000, 1'b0, 5'd0, 1'b0, 5'd0);
    idle_read(1'b1, 5'd7, 5'd7);
    step(1'b1, 1'b1, 5'd7, 32'h0000BBBB, 1'b1, 5'd7, 1'b1, 5'd7);
    idle_read(1'b1, 5'd7, 5'd7);

    // Randomized traffic, biased so that the bypass and $0 cases occur often.
    for (int i = 0; i < 400; i++) begin
      wa  = AW'($urandom_range(0, DEPTH - 1));
      ra1 = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, DEPTH - 1));
      ra2 = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, DEPTH - 1));
      step(1'b1, 1'($urandom_range(0, 1)), wa, $urandom,
           1'($urandom_range(0, 3) != 0), ra1, 1'($urandom_range(0, 3) != 0), ra2);
    end

    // Assert reset during RUN. The outputs and ready must drop asynchronously.
    step(1'b1, 1'b1, 5'd3, 32'h00000001, 1'b0, 5'd0, 1'b0, 5'd0);
    idle_read(1'b1, 5'd3, 5'd3);
    idle_read(1'b0, 5'd3, 5'd3);
    idle_read(1'b0, 5'd3, 5'd3);
    for (int i = 0; i < DEPTH + 2; i++) idle_read(1'b1, 5'd3, 5'd3);

    // Assert reset in the middle of a sweep. The sweep must restart from zero.
    for (int i = 0; i < 10; i++) idle_read(1'b1, 5'd3, 5'd3);
    step(1'b1, 1'b1, 5'd3, 32'h00000042, 1'b1, 5'd3, 1'b1, 5'd4);
    idle_read(1'b0, 5'd3, 5'd4);
    for (int i = 0; i < 10; i++) idle_read(1'b1, 5'd3, 5'd3);
    idle_read(1'b0, 5'd3, 5'd3);
    for (int i = 0; i < DEPTH + 3; i++) idle_read(1'b1, 5'd3, AW'(i));

    @(negedge clock);
    @(negedge clock);
    if (exp_q.size() != 0) begin
      n_mismatched++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
